gray_sched: RTL and testbench

GRAY_SCHED -- requirements
Module: gray_sched

---
 rtl/gray_sched.sv | 140 ++++++++++++++
 tb/tb_gray_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_sched.sv
// gray_sched: two-requester round-robin scheduler for a shared gray counter.
// A winner is granted, the counter is optionally cleared for one cycle, then
// enabled for the requested step count (or until an early abort), and the run
// ends with a single-cycle completion pulse carrying the requester index.
module gray_sched #(
  parameter int          STEP_W       = 3,
  parameter int unsigned CLR_ON_GRANT = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [1:0]        Req,
  input  logic [STEP_W-1:0] Steps0,
  input  logic [STEP_W-1:0] Steps1,
  input  logic              Abort,
  input  logic              CntOverflow,
  output logic [1:0]        Gnt,
  output logic              CntEn,
  output logic              CntClr,
  output logic              Busy,
  output logic              Done,
  output logic              DoneId,
  output logic              Wrapped,
  output logic              Aborted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [STEP_W:0] L_ONE      = (STEP_W+1)'(1);
  localparam logic [STEP_W:0] L_FULL_RUN = {1'b1, {STEP_W{1'b0}}};

  state_t            r_state;
  state_t            w_next;
  logic              r_ptr;        // index of the requester served last
  logic              r_idx;        // index of the requester currently granted
  logic [STEP_W:0]   r_remaining;
  logic              r_wrapped;
  logic              r_aborted;

  logic              w_winner;
  logic [STEP_W-1:0] w_steps;
  logic [STEP_W:0]   w_steps_ext;
  logic              w_last;

  // Round-robin pick and step-count expansion for the pending request.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    w_winner = 1'b0;
    unique case (Req)
      2'b01:   w_winner = 1'b0;
      2'b10:   w_winner = 1'b1;
      2'b11:   w_winner = ~r_ptr;
      default: w_winner = 1'b0;
    endcase
    w_steps     = w_winner ? Steps1 : Steps0;
    // A zero request field stands for the full 2^STEP_W run length.
    w_steps_ext = (w_steps == '0) ? L_FULL_RUN : {1'b0, w_steps};
    w_last      = (r_remaining == L_ONE);
  end

  // State register.
  always_ff @(posedge Clk or negedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode; Abort on the final RUN cycle finishes normally anyway.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (|Req) w_next = S_GRANT;
      S_GRANT: w_next = S_RUN;
      S_RUN:   if (w_last || Abort) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Run bookkeeping: winner capture on grant entry, countdown and flags in RUN.
  always_ff @(posedge Clk or negedge Reset) begin
    // NOTE: every control register is reset; the pointer starts at 1 so
    // requester 0 wins the first tie.
    if (!Reset) begin
      r_ptr       <= 1'b1;
      r_idx       <= 1'b0;
      r_remaining <= '0;
      r_wrapped   <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (|Req) begin
            r_ptr       <= w_winner;
            r_idx       <= w_winner;
            r_remaining <= w_steps_ext;
            r_wrapped   <= 1'b0;
            r_aborted   <= 1'b0;
          end
        end
        S_RUN: begin
          r_remaining <= r_remaining - L_ONE;
          if (CntOverflow)       r_wrapped <= 1'b1;
          if (Abort && !w_last)  r_aborted <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Moore output decode from the registered state.
  always_comb begin
    Gnt     = 2'b00;
    CntEn   = 1'b0;
    CntClr  = 1'b0;
    Busy    = (r_state != S_IDLE);
    Done    = 1'b0;
    DoneId  = 1'b0;
    Wrapped = 1'b0;
    Aborted = 1'b0;
    if (r_state != S_IDLE) Gnt = r_idx ? 2'b10 : 2'b01;
    unique case (r_state)
      S_GRANT: CntClr = (CLR_ON_GRANT != 0);
      S_RUN:   CntEn  = 1'b1;
      S_DONE: begin
        Done    = 1'b1;
        DoneId  = r_idx;
        Wrapped = r_wrapped;
        Aborted = r_aborted;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gray_sched.sv
// tb_gray_sched: table-driven vectors plus hand sequences for round-robin,
// mid-run reset and the no-clear variant. Completed runs are scored against
// a queue of expected results filled when each request is driven.
module tb_gray_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic [2:0] steps0 = '0, steps1 = '0;
  logic       abort = 1'b0, ovf = 1'b0;
  logic [1:0] gnt;
  logic       cnt_en, cnt_clr, busy, done, done_id, wrapped, aborted;

  logic [1:0] nc_req = 2'b00;
  logic [2:0] nc_s0 = '0;
  logic [1:0] nc_gnt;
  logic       nc_en, nc_clr, nc_busy, nc_done, nc_done_id, nc_wrapped, nc_aborted;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  gray_sched #(.STEP_W(3), .CLR_ON_GRANT(1)) u_dut (
    .Clk(clk), .Reset(rst_n), .Req(req), .Steps0(steps0), .Steps1(steps1),
    .Abort(abort), .CntOverflow(ovf), .Gnt(gnt), .CntEn(cnt_en),
    .CntClr(cnt_clr), .Busy(busy), .Done(done), .DoneId(done_id),
    .Wrapped(wrapped), .Aborted(aborted)
  );

  gray_sched #(.STEP_W(3), .CLR_ON_GRANT(0)) u_dut_nc (
    .Clk(clk), .Reset(rst_n), .Req(nc_req), .Steps0(nc_s0), .Steps1(3'd0),
    .Abort(1'b0), .CntOverflow(1'b0), .Gnt(nc_gnt), .CntEn(nc_en),
    .CntClr(nc_clr), .Busy(nc_busy), .Done(nc_done), .DoneId(nc_done_id),
    .Wrapped(nc_wrapped), .Aborted(nc_aborted)
  );

  typedef struct {
    logic [1:0] req;
    logic [2:0] s0;
    logic [2:0] s1;
    int         abort_at;   // RUN cycle (1-based) carrying Abort, 0 = none
    int         ovf_at;     // RUN cycle carrying CntOverflow, 0 = none
    logic       exp_id;
    int         exp_run;
    logic       exp_wrap;
    logic       exp_abort;
  } vec_t;

  typedef struct {
    logic id;
    int   run;
    logic wrap;
    logic abrt;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: accumulate per-run activity, compare at each Done.
  initial begin
    int   g_cnt, e_cnt, c_cnt;
    exp_t e;
    g_cnt = 0; e_cnt = 0; c_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        g_cnt = 0; e_cnt = 0; c_cnt = 0;
      end else begin
        if (gnt != 2'b00) g_cnt++;
        if (cnt_en)       e_cnt++;
        if (cnt_clr)      c_cnt++;
        if (done) begin
          if (sb_q.size() == 0) begin
            check("sb_unexpected_done", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("sb_done_id",   done_id, e.id);
            check("sb_gnt_hold",  gnt, e.id ? 2'b10 : 2'b01);
            check("sb_en_cycles", e_cnt, e.run);
            check("sb_gnt_cycles", g_cnt, e.run + 2);
            check("sb_clr_cycles", c_cnt, 1);
            check("sb_wrapped",   wrapped, e.wrap);
            check("sb_aborted",   aborted, e.abrt);
          end
          g_cnt = 0; e_cnt = 0; c_cnt = 0;
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, gnt, 0);
    check({tag, "_en"}, cnt_en, 0);
    check({tag, "_clr"}, cnt_clr, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_done_id"}, done_id, 0);
    check({tag, "_wrapped"}, wrapped, 0);
    check({tag, "_aborted"}, aborted, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    req = v.req; steps0 = v.s0; steps1 = v.s1;
    @(posedge clk);
    #1;
    check({tag, "_gnt_k1"}, gnt, v.exp_id ? 2'b10 : 2'b01);
    check({tag, "_clr_grant"}, cnt_clr, 1);
    check({tag, "_en_grant"}, cnt_en, 0);
    req = 2'b00;
    e.id = v.exp_id; e.run = v.exp_run; e.wrap = v.exp_wrap; e.abrt = v.exp_abort;
    sb_q.push_back(e);
    @(negedge clk);  // GRANT cycle
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) check({tag, "_en_k2"}, cnt_en, 1);
      if (!cnt_en) break;
      abort = (i == v.abort_at);
      ovf   = (i == v.ovf_at);
    end
    abort = 1'b0; ovf = 1'b0;
    for (int i = 0; i < 4 && busy; i++) @(negedge clk);
    check({tag, "_idle_after"}, busy, 0);
  endtask

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int grants, done_cyc, cnt, done_seen, clr_c, en_c, dn_c;
    exp_t e;
    vec_t v;

    //          req    s0    s1  abort ovf id run wrap abrt
    vecs[0] = '{2'b01, 3'd3, 3'd0, 0, 0, 1'b0, 3, 1'b0, 1'b0};
    vecs[1] = '{2'b10, 3'd0, 3'd0, 0, 4, 1'b1, 8, 1'b1, 1'b0};
    vecs[2] = '{2'b01, 3'd5, 3'd0, 2, 0, 1'b0, 2, 1'b0, 1'b1};
    vecs[3] = '{2'b01, 3'd5, 3'd0, 5, 0, 1'b0, 5, 1'b0, 1'b0};
    vecs[4] = '{2'b11, 3'd2, 3'd1, 0, 0, 1'b1, 1, 1'b0, 1'b0};
    vecs[5] = '{2'b11, 3'd2, 3'd1, 0, 0, 1'b0, 2, 1'b0, 1'b0};
    vecs[6] = '{2'b10, 3'd0, 3'd7, 0, 7, 1'b1, 7, 1'b1, 1'b0};
    vecs[7] = '{2'b01, 3'd1, 3'd0, 1, 0, 1'b0, 1, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Both requesters hold Req: grants must alternate 0,1,0,1 from reset.
    do_reset();
    e = '{1'b0, 2, 1'b0, 1'b0}; sb_q.push_back(e);
    e = '{1'b1, 1, 1'b0, 1'b0}; sb_q.push_back(e);
    e = '{1'b0, 2, 1'b0, 1'b0}; sb_q.push_back(e);
    e = '{1'b1, 1, 1'b0, 1'b0}; sb_q.push_back(e);
    req = 2'b11; steps0 = 3'd2; steps1 = 3'd1;
    grants = 0; done_cyc = -100;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (cnt_clr) begin
        grants++;
        if (grants == 2) check("rr_regrant_gap", c - done_cyc, 2);
        if (grants == 4) req = 2'b00;
      end
      if (done) done_cyc = c;
      if (grants == 4 && !busy) break;
    end
    check("rr_grants", grants, 4);
    check("rr_idle", busy, 0);

    // Reset during the 3rd RUN cycle.
    @(negedge clk);
    req = 2'b01; steps0 = 3'd5;
    @(posedge clk);
    #1;
    req = 2'b00;
    cnt = 0;
    for (int c = 0; c < 10 && cnt < 3; c++) begin
      @(negedge clk);
      if (cnt_en) cnt++;
    end
    check("mid_reset_reached_run3", cnt, 3);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) done_seen = 1;
    end
    check("mid_reset_no_done", done_seen, 0);
    v = '{2'b11, 3'd1, 3'd2, 0, 0, 1'b0, 1, 1'b0, 1'b0};
    run_vec(v, "post_reset_tie");

    // No-clear variant: single step run.
    @(negedge clk);
    nc_req = 2'b01; nc_s0 = 3'd1;
    @(posedge clk);
    #1;
    check("nc_gnt", nc_gnt, 2'b01);
    nc_req = 2'b00;
    clr_c = 0; en_c = 0; dn_c = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (nc_clr)  clr_c++;
      if (nc_en)   en_c++;
      if (nc_done) dn_c++;
    end
    check("nc_clr_cycles", clr_c, 0);
    check("nc_en_cycles", en_c, 1);
    check("nc_done_pulses", dn_c, 1);
    check("nc_idle", nc_busy, 0);

    check("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
